mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the shared MIPS datapath (ALU, sign-extend, shift-left-2, muxes, PC adder) multi-cycle.
//  Decodes opcode/funct, drives every datapath select/enable and handshakes with a single shared instr/data memory.
//  Counts retired instructions; flags illegal opcodes and memory timeouts. Sits beside the datapath in the CPU top.
// PARAMETERS
//  TIMEOUT  16  max consecutive cycles waiting on mem_ready in one memory state before bus_error
//  CNT_W    32  width of retired-instruction counter
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high
//  opcode        in   6      IR[31:26]
//  funct         in   6      IR[5:0]
//  zero          in   1      ALU zero flag
//  mem_ready     in   1      memory completes the current access this cycle
//  mem_req       out  1      memory access request, held until mem_ready
//  mem_we        out  1      1=write, 0=read (valid with mem_req)
//  iord          out  1      memory address: 0=PC, 1=ALUOut
//  ir_write      out  1      latch instruction register
//  pc_en         out  1      PC write enable
//  pc_source     out  2      00=ALU result, 01=ALUOut (branch target), 10=jump target
//  alu_src_a     out  1      0=PC, 1=reg A
//  alu_src_b     out  2      00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op        out  4      0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
//  reg_dst       out  1      0=rt, 1=rd
//  mem_to_reg    out  1      0=ALUOut, 1=MDR
//  reg_write     out  1      register file write enable
//  illegal_instr out  1      1-cycle pulse on unsupported opcode/funct
//  bus_error     out  1      1-cycle pulse on memory timeout
//  retired       out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Outputs: pure function of registered state, except ir_write/pc_en in FETCH, which are gated by mem_ready.
//  Reset (async): state=IDLE, wait_cnt=0, retired=0. In IDLE all outputs 0, alu_op=0010. IDLE->FETCH next cycle.
//  FETCH: mem_req=1, iord=0, src_a=0, src_b=01, add, pc_source=00; on mem_ready: ir_write=pc_en=1 -> DECODE.
//  DECODE: src_a=0, src_b=11, add (branch target into ALUOut). Next state by opcode:
//    000000 R (funct 20 add, 21 addu, 22 sub, 24 and, 25 or, 2A slt) -> EXEC_R; bad funct -> TRAP
//    001000 addi / 001101 ori -> EXEC_I; 100011 lw / 101011 sw -> MEM_ADDR
//    000100 beq / 000101 bne -> BRANCH; 000010 j -> JUMP; other -> TRAP
//  EXEC_R: src_a=1, src_b=00, alu_op from funct (add/addu both 0010) -> R_WB: reg_dst=1, reg_write=1 -> FETCH.
//  EXEC_I: src_a=1, src_b=10, addi->0010, ori->0001 -> I_WB: reg_dst=0, reg_write=1 -> FETCH.
//    ori zero-extension is the datapath's concern; the controller only selects src_b=10.
//  MEM_ADDR: src_a=1, src_b=10, add -> MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD: mem_req=1, iord=1, we=0; on mem_ready -> MEM_WB: mem_to_reg=1, reg_dst=0, reg_write=1 -> FETCH.
//  MEM_WR: mem_req=1, iord=1, we=1; on mem_ready -> FETCH.
//  BRANCH: src_a=1, src_b=00, sub, pc_source=01.
//    pc_en = (beq & zero) | (bne & ~zero) -> FETCH.
//  JUMP: pc_source=10, pc_en=1 -> FETCH. TRAP: illegal_instr=1, no writes -> FETCH (PC already +4).
//  Latency (zero wait): beq/bne/j 3; R, addi, ori, sw 4; lw 5. Each wait cycle adds 1.
//  Memory wait: wait_cnt clears on entry to FETCH/MEM_RD/MEM_WR; +1 per cycle with mem_ready=0.
//    wait_cnt==TIMEOUT-1 with mem_ready=0: bus_error pulse, abort -> FETCH, no ir/pc/reg write.
//    mem_ready wins over timeout in the same cycle. mem_ready outside memory states is ignored.
//  retired +1 (mod 2^CNT_W) on the final cycle of R_WB, I_WB, MEM_WB, BRANCH, JUMP, and of MEM_WR when mem_ready=1.
//    TRAP and aborted accesses do not count.
//  opcode/funct are sampled only in DECODE and EXEC_R (IR is stable there).
//  Reset mid-instruction: immediate abort to IDLE. Pending reg/pc writes are lost.
// STRUCTURE
//  Package mips_ctrl_pkg holds: state enum (IDLE, FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_RD,
//  MEM_WB, MEM_WR, BRANCH, JUMP, TRAP), opcode/funct localparams, ALU op codes, src_b/pc_source encodings.
//  One sub-module: mips_funct_decode (funct -> alu_op, valid), combinational; shared with future ALU control.
// TESTING
//  1. reset released, mem_ready=1 -> IDLE then FETCH; pc_en=ir_write=1 in FETCH; retired=0.
//  2. add (op 00, funct 20), mem_ready=1 -> 4 cycles; R_WB reg_write=1, reg_dst=1, alu_op 0010 in EXEC_R; retired=1.
//  3. lw (op 23h), mem_ready low 3 cycles in MEM_RD -> lw completes in 8 cycles; mem_to_reg=1 in MEM_WB.
//  4. beq, zero=1 -> pc_en=1, pc_source=01 in BRANCH. bne, zero=1 -> pc_en=0. Both: retired +1.
//  5. opcode 3Fh -> illegal_instr pulse, no reg_write/pc_en, back to FETCH, retired unchanged.
//  6. mem_ready held 0 in FETCH -> bus_error in 16th wait cycle, then refetch. Reset asserted in MEM_WB -> IDLE, reg_write=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// values, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB,
    MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that own the memory bus and are subject to the wait timeout.
  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mips_funct_decode.sv
// R-type funct field to ALU operation decode; valid=0 flags an unsupported funct.
module mips_funct_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: alu_op = ALU_ADD;
      FN_SUB:          alu_op = ALU_SUB;
      FN_AND:          alu_op = ALU_AND;
      FN_OR:           alu_op = ALU_OR;
      FN_SLT:          alu_op = ALU_SLT;
      default:         valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath, handshakes with the
// unified memory, counts retired instructions and flags illegal opcodes / bus timeouts.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_bne, is_ori, is_sw;
  logic              timeout, retire;
  logic [3:0]        r_alu_op;
  logic              r_valid;

  mips_funct_decode u_funct_decode (
    .funct  (funct),
    .alu_op (r_alu_op),
    .valid  (r_valid)
  );

  assign timeout   = is_mem_state(state) && !mem_ready &&
                     (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign bus_error = timeout;
  assign retire    = (state == R_WB) || (state == I_WB) || (state == MEM_WB) ||
                     (state == BRANCH) || (state == JUMP) ||
                     ((state == MEM_WR) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      retired  <= '0;
      is_bne   <= 1'b0;
      is_ori   <= 1'b0;
      is_sw    <= 1'b0;
    end else begin
      state <= state_next;
      // A memory state is only re-entered by staying put, so any exit clears the count.
      if (is_mem_state(state) && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
      if (retire)
        retired <= retired + CNT_W'(1);
      // Opcode is only trusted in DECODE; keep what later states need.
      if (state == DECODE) begin
        is_bne <= (opcode == OP_BNE);
        is_ori <= (opcode == OP_ORI);
        is_sw  <= (opcode == OP_SW);
      end
    end
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready)
          state_next = DECODE;
        else if (timeout)
          state_next = FETCH;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:       state_next = r_valid ? EXEC_R : TRAP;
          OP_ADDI, OP_ORI: state_next = EXEC_I;
          OP_LW, OP_SW:   state_next = MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_J:           state_next = JUMP;
          default:        state_next = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_op     = r_alu_op;
        state_next = R_WB;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = is_ori ? ALU_OR : ALU_ADD;
        state_next = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = is_sw ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)
          state_next = MEM_WB;
        else if (timeout)
          state_next = FETCH;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready || timeout)
          state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_en      = is_bne ? !zero : zero;
        state_next = FETCH;
      end
      JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_en      = 1'b1;
        state_next = FETCH;
      end
      TRAP: begin
        illegal_instr = 1'b1;
        state_next    = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
